// File: rtl/mrav_bus_ctrl.sv
// Single-master bus controller: decodes a core request to one of NUM_DEV
// address windows, strobes that device until it answers or times out, then
// returns a one-cycle done pulse with optional error flag to the core.
module mrav_bus_ctrl #(
    parameter int                            NUM_DEV        = 4,
    parameter int                            ADDR_WIDTH     = 32,
    parameter int                            DATA_WIDTH     = 32,
    parameter logic [NUM_DEV*ADDR_WIDTH-1:0] DEV_ADDR_LO    = '0,
    parameter logic [NUM_DEV*ADDR_WIDTH-1:0] DEV_ADDR_HI    = '0,
    parameter int                            TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          core_read,
    input  logic                          core_write,
    input  logic [ADDR_WIDTH-1:0]         mrav_addr,
    input  logic [DATA_WIDTH-1:0]         mrav_data_out,
    output logic [DATA_WIDTH-1:0]         mrav_data_in,
    output logic                          mrav_read_done,
    output logic                          mrav_write_done,
    output logic                          mrav_bus_err,
    output logic [NUM_DEV-1:0]            dev_read,
    output logic [NUM_DEV-1:0]            dev_write,
    input  logic [NUM_DEV-1:0]            dev_read_done,
    input  logic [NUM_DEV-1:0]            dev_write_done,
    output logic [ADDR_WIDTH-1:0]         dev_addr,
    output logic [DATA_WIDTH-1:0]         dev_cpu_data_out,
    input  logic [NUM_DEV*DATA_WIDTH-1:0] dev_cpu_data_in
);

    // Handshake: the core holds core_read/core_write as a level; it is sampled
    // only in IDLE and answered by exactly one mrav_*_done pulse, with
    // mrav_bus_err valid in that same cycle. Devices see a level strobe and
    // answer with a done level that is only honoured while strobed.
    localparam int SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DEV-1:0]    rd_strobe_q, rd_strobe_d;
    logic [NUM_DEV-1:0]    wr_strobe_q, wr_strobe_d;
    logic                  rd_done_q, rd_done_d;
    logic                  wr_done_q, wr_done_d;
    logic                  err_q, err_d;

    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic                  done_hit;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timed_out;

    function automatic logic [NUM_DEV-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_DEV-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx == SEL_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Walking down from the top index leaves the lowest matching window selected.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if ((mrav_addr >= DEV_ADDR_LO[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (mrav_addr <= DEV_ADDR_HI[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        done_hit  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                done_hit  = is_read_q ? dev_read_done[i] : dev_write_done[i];
                sel_rdata = dev_cpu_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        rd_strobe_d = '0;
        wr_strobe_d = '0;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (core_read || core_write) begin
                    addr_d    = mrav_addr;
                    wdata_d   = mrav_data_out;
                    is_read_d = core_read;
                    sel_d     = hit_idx;
                    cnt_d     = CNT_W'(1);
                    if (core_read && core_write) begin
                        state_d   = ST_RESP;
                        rd_done_d = 1'b1;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                    end else if (!hit) begin
                        state_d   = ST_RESP;
                        rd_done_d = core_read;
                        wr_done_d = core_write;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        rd_strobe_d = core_read  ? onehot(hit_idx) : '0;
                        wr_strobe_d = core_write ? onehot(hit_idx) : '0;
                    end
                end
            end
            ST_ACCESS: begin
                // A done arriving in the last allowed cycle is checked first, so it wins.
                if (done_hit) begin
                    state_d   = ST_RESP;
                    rd_done_d = is_read_q;
                    wr_done_d = !is_read_q;
                    if (is_read_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (timed_out) begin
                    state_d   = ST_RESP;
                    rd_done_d = is_read_q;
                    wr_done_d = !is_read_q;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    rd_strobe_d = rd_strobe_q;
                    wr_strobe_d = wr_strobe_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            rd_strobe_q <= '0;
            wr_strobe_q <= '0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            rd_strobe_q <= rd_strobe_d;
            wr_strobe_q <= wr_strobe_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
        end
    end

    assign mrav_data_in     = rdata_q;
    assign mrav_read_done   = rd_done_q;
    assign mrav_write_done  = wr_done_q;
    assign mrav_bus_err     = err_q;
    assign dev_read         = rd_strobe_q;
    assign dev_write        = wr_strobe_q;
    assign dev_addr         = addr_q;
    assign dev_cpu_data_out = wdata_q;

endmodule
